// File: rtl/hex_display_scanner_if.sv
// Pin-side bundle between a datapath and hex_display_scanner.
// Defining SEG_DP_EN adds the decimal-point signals dp_in and seg_dp.
interface hex_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);

    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic                    enable;
    logic                    lz_blank;
    logic [6:0]              segments;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    frame_done;
`ifdef SEG_DP_EN
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    seg_dp;

    modport master (
        output value_in, load, enable, lz_blank, dp_in,
        input  segments, digit_sel, frame_done, seg_dp
    );

    modport slave (
        input  value_in, load, enable, lz_blank, dp_in,
        output segments, digit_sel, frame_done, seg_dp
    );
`else
    modport master (
        output value_in, load, enable, lz_blank,
        input  segments, digit_sel, frame_done
    );

    modport slave (
        input  value_in, load, enable, lz_blank,
        output segments, digit_sel, frame_done
    );
`endif

endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 7-segment hex scanner with tear-free frame updates and leading-zero blanking.
// Defining SEG_DP_EN adds a per-digit decimal point (dp_in -> seg_dp).
module hex_display_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    hex_display_scanner_if.slave bus
);

    localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{SEL_ACTIVE_LOW}};

    logic [PRE_W-1:0]      prescaler_q, prescaler_d;
    logic [IDX_W-1:0]      digitIdx_q, digitIdx_d;
    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic [VAL_W-1:0]      display_q, display_d;
    logic [6:0]            segments_q, segments_d;
    logic [NUM_DIGITS-1:0] digitSel_q, digitSel_d;
    logic                  frameDone_q, frameDone_d;

    logic                  termCount;
    logic                  frameWrap;
    logic [3:0]            curNibble;
    logic                  leadZero;
    logic                  zeroRun;
    logic [NUM_DIGITS-1:0] oneHot;

`ifdef SEG_DP_EN
    logic [NUM_DIGITS-1:0] dpShadow_q, dpShadow_d;
    logic [NUM_DIGITS-1:0] dpDisplay_q, dpDisplay_d;
    logic                  segDp_q, segDp_d;
    logic                  curDp;
`endif

    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h18;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    always_comb begin
        termCount   = (prescaler_q == PRE_LAST);
        frameWrap   = termCount && (digitIdx_q == IDX_LAST);
        prescaler_d = termCount ? '0 : prescaler_q + PRE_W'(1);
        digitIdx_d  = digitIdx_q;
        if (termCount) begin
            digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + IDX_W'(1);
        end
        frameDone_d = frameWrap;
    end

    // A load landing on the wrap edge bypasses the shadow so it is not a frame late.
    always_comb begin
        shadow_d  = bus.load ? bus.value_in : shadow_q;
        display_d = display_q;
        if (frameWrap) begin
            display_d = bus.load ? bus.value_in : shadow_q;
        end
    end

    // Outputs are built from next-state index/display so they change in step with the index.
    always_comb begin
        curNibble = 4'h0;
        leadZero  = 1'b0;
        zeroRun   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zeroRun = zeroRun && (display_d[4*k +: 4] == 4'h0);
            if (digitIdx_d == IDX_W'(k)) begin
                curNibble = display_d[4*k +: 4];
                leadZero  = zeroRun && (k != 0);
            end
        end
    end

    always_comb begin
        oneHot     = NUM_DIGITS'(1) << digitIdx_d;
        segments_d = 7'h7F;
        digitSel_d = SEL_OFF;
        if (bus.enable) begin
            digitSel_d = SEL_ACTIVE_LOW ? ~oneHot : oneHot;
            if (!(bus.lz_blank && leadZero)) begin
                segments_d = hexToSeg(curNibble);
            end
        end
    end

`ifdef SEG_DP_EN
    // Leading-zero blanking deliberately leaves the decimal point alone.
    always_comb begin
        dpShadow_d  = bus.load ? bus.dp_in : dpShadow_q;
        dpDisplay_d = dpDisplay_q;
        if (frameWrap) begin
            dpDisplay_d = bus.load ? bus.dp_in : dpShadow_q;
        end
        curDp = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digitIdx_d == IDX_W'(k)) begin
                curDp = dpDisplay_d[k];
            end
        end
        segDp_d = !(bus.enable && curDp);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dpShadow_q  <= '0;
            dpDisplay_q <= '0;
            segDp_q     <= 1'b1;
        end else begin
            dpShadow_q  <= dpShadow_d;
            dpDisplay_q <= dpDisplay_d;
            segDp_q     <= segDp_d;
        end
    end

    assign bus.seg_dp = segDp_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescaler_q <= '0;
            digitIdx_q  <= '0;
            shadow_q    <= '0;
            display_q   <= '0;
            segments_q  <= 7'h7F;
            digitSel_q  <= SEL_OFF;
            frameDone_q <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            digitIdx_q  <= digitIdx_d;
            shadow_q    <= shadow_d;
            display_q   <= display_d;
            segments_q  <= segments_d;
            digitSel_q  <= digitSel_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign bus.segments   = segments_q;
    assign bus.digit_sel  = digitSel_q;
    assign bus.frame_done = frameDone_q;

endmodule
